fft_sequencer: RTL and testbench
================================

# fft_sequencer

Controller that sequences a single shared radix-2 `butterfly` datapath through an in-place N-point decimation-in-time FFT held in an external dual-port sample RAM. On `start` it walks all log2(N) stages and issues one butterfly per cycle: two read addresses plus a twiddle-ROM address. It then issues the matching write-back addresses one cycle later, inserting a one-cycle drain bubble at every stage boundary. The block sits between the frame loader, which leaves samples in bit-reversed order, and the spectrum/magnitude logic, which waits for `done`.

## Interface
- `N`, 16, FFT length; power of two, at least 4.
- `LOG2N`, 4, log2(N); must equal log2 of `N`.
- `AW`, `LOG2N`, sample RAM address width.
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a transform when sampled high in IDLE; ignored otherwise.
- `busy`  out  1  high from the cycle after `start` is accepted through the final drain cycle.
- `done`  out  1  one-cycle pulse in the cycle after the final write.
- `stage`  out  LOG2N  current stage index, 0..LOG2N-1.
- `rd_en`  out  1  read strobe for both RAM ports.
- `rd_addr_a`, `rd_addr_b`  out  AW  butterfly operand addresses; the `butterfly` inputs are `inA` and `inB`.
- `tw_addr`  out  LOG2N-1  twiddle ROM index, valid with `rd_en`.
- `wr_en`  out  1  write strobe for both RAM ports.
- `wr_addr_a`, `wr_addr_b`  out  AW  write-back addresses for `outA` and `outB`.

## Operation
- Both the RAM and the twiddle ROM read synchronously, with 1-cycle latency. The `butterfly` is combinational between RAM/ROM output and RAM write data.
- Address generation for stage s and butterfly index k (0..N/2-1):
  - half = 1<<s
  - pos = k & (half-1)
  - group = k>>s
  - a = group*2*half + pos
  - b = a + half
  - tw = pos << (LOG2N-1-s)
- All arithmetic is unsigned, in AW bits, with no wrap; b never exceeds N-1.
- Write pipeline: `wr_en`, `wr_addr_a` and `wr_addr_b` are `rd_en`, `rd_addr_a` and `rd_addr_b` delayed by exactly one register stage.
- FSM states:
  - IDLE: outputs quiet. `start` loads s=0 and k=0, then goes to RUN.
  - RUN: `rd_en`=1 and k increments each cycle. When k=N/2-1 is issued, go to DRAIN.
  - DRAIN: `rd_en`=0; the last write of the stage occurs here.
    - If s<LOG2N-1: increment s, clear k, go to RUN.
    - Otherwise go to IDLE and assert `done` in the next cycle.
- The DRAIN bubble is mandatory. It prevents stage s+1 reading an address in the same cycle that stage s writes it.
- `start` while `busy` is ignored, with no restart and no queuing. `start` held high in the same cycle `done` pulses starts a new transform, because the FSM is in IDLE.
- `stage` holds its last value (LOG2N-1) after completion until the next `start`.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE and all outputs 0, including `wr_en`. Any in-flight write is dropped.
- Reset mid-transform aborts immediately. RAM contents are then undefined, and no `done` is produced.
- Cycle 0 is the first cycle after the edge that samples `start`.
- Stage s reads occupy cycles s*(N/2+1) .. s*(N/2+1)+N/2-1. Its writes occur one cycle later. Its drain cycle is s*(N/2+1)+N/2.
- `busy`=1 for cycles 0 .. LOG2N*(N/2+1)-1.
- `done`=1 and `busy`=0 in cycle LOG2N*(N/2+1). For N=16 that is cycle 36.
- Throughput: one butterfly per cycle inside a stage.
- All outputs are registered; no combinational path from `start` to any output.

## Test plan
- Reset then idle: hold `rst` 3 cycles, then `start`=0 for 10 cycles -> all outputs stay 0.
- N=16 stage-0 sequence: pulse `start` -> cycles 0 and 1 give (rd_addr_a,rd_addr_b,tw_addr) = (0,1,0) and (2,3,0). `wr_en` rises in cycle 1 with `wr_addr` (0,1).
- Deep stages, N=16:
  - stage 2, k=5 -> (9,13,2)
  - stage 3, k=7 -> (7,15,7)
  - `rd_en`=0 in cycles 8, 17, 26 and 35
- Completion and golden model, N=16:
  - `done` pulses only in cycle 36, with `busy` falling the same cycle.
  - With the RAM and `butterfly` attached, a bit-reversed impulse at x[0] yields an all-equal spectrum.
- `start` asserted at cycles 5 and 20 mid-transform -> the sequence is unchanged and `done` still arrives at cycle 36. `start` held high at cycle 36 -> a new transform begins with stage=0 at cycle 37.
- `rst` asserted at cycle 12 -> `wr_en` and `rd_en` drop asynchronously, there is no `done`, and a subsequent `start` repeats the full cycle-0 sequence.

Source files
------------

// File: rtl/fft_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT over a shared butterfly.
// Issues one butterfly read per cycle, with write-back one cycle later and a drain bubble per stage.
module fft_sequencer #(
    parameter int N     = 16,
    parameter int LOG2N = 4,
    parameter int AW    = LOG2N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr_a,
    output logic [AW-1:0]    rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr_a,
    output logic [AW-1:0]    wr_addr_b
);

    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0]    K_LAST = KW'(N / 2 - 1);
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] s_q, s_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_en_q, rd_en_d;
    logic [AW-1:0]    rd_a_q, rd_a_d;
    logic [AW-1:0]    rd_b_q, rd_b_d;
    logic [KW-1:0]    tw_q, tw_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_a_q, wr_a_d;
    logic [AW-1:0]    wr_b_q, wr_b_d;

    logic             issue;
    logic [AW-1:0]    k_ext, half, pos, addr_a;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        issue   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    s_d     = '0;
                    k_d     = '0;
                    issue   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d   = k_q + KW'(1);
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                // The bubble lets the last write of stage s land before stage s+1 reads.
                if (s_q != S_LAST) begin
                    state_d = RUN;
                    s_d     = s_q + LOG2N'(1);
                    k_d     = '0;
                    issue   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand addresses for the butterfly being issued next cycle (stage s_d, index k_d).
        k_ext  = AW'(k_d);
        half   = AW'(1) << s_d;
        pos    = k_ext & (half - AW'(1));
        addr_a = ((k_ext >> s_d) << (s_d + LOG2N'(1))) | pos;

        rd_en_d = issue;
        rd_a_d  = issue ? addr_a : '0;
        rd_b_d  = issue ? addr_a + half : '0;
        tw_d    = issue ? (KW'(pos) << (S_LAST - s_d)) : '0;

        wr_en_d = rd_en_q;
        wr_a_d  = rd_a_q;
        wr_b_d  = rd_b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            wr_en_q <= 1'b0;
            wr_a_q  <= '0;
            wr_b_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
            wr_en_q <= wr_en_d;
            wr_a_q  <= wr_a_d;
            wr_b_q  <= wr_b_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = s_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_addr   = tw_q;
    assign wr_en     = wr_en_q;
    assign wr_addr_a = wr_a_q;
    assign wr_addr_b = wr_b_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: cycle-exact scoreboard of all outputs plus a RAM/butterfly model
// whose final contents are compared against a direct DFT.
module tb_fft_sequencer;

    localparam int  N     = 16;
    localparam int  LOG2N = 4;
    localparam int  AW    = 4;
    localparam int  HALF  = N / 2;
    localparam int  TOTAL = LOG2N * (HALF + 1);
    localparam real PI    = 3.14159265358979323846;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] stage;
    logic             rd_en;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr_a;
    logic [AW-1:0]    wr_addr_b;

    fft_sequencer #(.N(N), .LOG2N(LOG2N), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic [LOG2N-1:0] stage;
        logic             rd_en;
        logic [AW-1:0]    ra;
        logic [AW-1:0]    rb;
        logic [LOG2N-2:0] tw;
        logic             wr_en;
        logic [AW-1:0]    wa;
        logic [AW-1:0]    wb;
    } obs_t;

    obs_t             exp_q[$];
    int               errors = 0;
    int               checks = 0;
    logic [LOG2N-1:0] idle_stage = '0;

    // Sample RAM (1-cycle read, read-first) with the butterfly between read data and write data.
    real ram_re[N];
    real ram_im[N];
    real lat_ar, lat_ai, lat_br, lat_bi;
    int  lat_tw;

    always @(posedge clk) begin : ram_model
        real w_re, w_im, t_re, t_im, oa_re, oa_im, ob_re, ob_im;
        logic do_wr;
        logic [AW-1:0] wa, wb;
        do_wr = wr_en;
        wa    = wr_addr_a;
        wb    = wr_addr_b;
        w_re  = $cos(2.0 * PI * lat_tw / N);
        w_im  = -$sin(2.0 * PI * lat_tw / N);
        t_re  = lat_br * w_re - lat_bi * w_im;
        t_im  = lat_br * w_im + lat_bi * w_re;
        oa_re = lat_ar + t_re;
        oa_im = lat_ai + t_im;
        ob_re = lat_ar - t_re;
        ob_im = lat_ai - t_im;
        if (rd_en) begin
            lat_ar = ram_re[rd_addr_a];
            lat_ai = ram_im[rd_addr_a];
            lat_br = ram_re[rd_addr_b];
            lat_bi = ram_im[rd_addr_b];
            lat_tw = int'(tw_addr);
        end
        if (do_wr) begin
            ram_re[wa] = oa_re;
            ram_im[wa] = oa_im;
            ram_re[wb] = ob_re;
            ram_im[wb] = ob_im;
        end
    end

    function automatic obs_t sample_dut();
        obs_t o;
        o.busy  = busy;
        o.done  = done;
        o.stage = stage;
        o.rd_en = rd_en;
        o.ra    = rd_addr_a;
        o.rb    = rd_addr_b;
        o.tw    = tw_addr;
        o.wr_en = wr_en;
        o.wa    = wr_addr_a;
        o.wb    = wr_addr_b;
        return o;
    endfunction

    function automatic obs_t next_exp();
        obs_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end else begin
            e       = '0;
            e.stage = idle_stage;
        end
        return e;
    endfunction

    function automatic int bitrev(input int n);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r |= ((n >> i) & 1) << (LOG2N - 1 - i);
        return r;
    endfunction

    // Expected outputs for cycles 0..TOTAL of one transform, from the stage/index formulas.
    task automatic push_transform();
        obs_t e, prev;
        int hf, pos, grp;
        prev = '0;
        for (int s = 0; s < LOG2N; s++) begin
            hf = 1 << s;
            for (int k = 0; k < HALF; k++) begin
                pos     = k % hf;
                grp     = k / hf;
                e       = '0;
                e.busy  = 1'b1;
                e.stage = LOG2N'(s);
                e.rd_en = 1'b1;
                e.ra    = AW'(grp * 2 * hf + pos);
                e.rb    = AW'(grp * 2 * hf + pos + hf);
                e.tw    = (LOG2N-1)'(pos * (N / (2 * hf)));
                e.wr_en = prev.rd_en;
                e.wa    = prev.ra;
                e.wb    = prev.rb;
                exp_q.push_back(e);
                prev = e;
            end
            e       = '0;
            e.busy  = 1'b1;
            e.stage = LOG2N'(s);
            e.wr_en = prev.rd_en;
            e.wa    = prev.ra;
            e.wb    = prev.rb;
            exp_q.push_back(e);
            prev = e;
        end
        e       = '0;
        e.done  = 1'b1;
        e.stage = LOG2N'(LOG2N - 1);
        exp_q.push_back(e);
        idle_stage = LOG2N'(LOG2N - 1);
    endtask

    task automatic drive_start(input logic v);
        start = v;
        if (v && !rst && exp_q.size() == 0) begin
            push_transform();
            $display("start accepted at t=%0t: %0d cycles queued", $time, exp_q.size());
        end
    endtask

    task automatic test_reset();
        obs_t e, a;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = sample_dut();
        checks++;
        if (a !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", a);
        end
        exp_q.delete();
        idle_stage = '0;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            e = next_exp();
            a = sample_dut();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d got=%h exp=%h", c, a, e);
            end
            drive_start(1'b0);
            @(negedge clk);
        end
        $display("reset/idle test: %0d cycles observed", 10);
    endtask

    task automatic test_stage0_sequence();
        obs_t e, a;
        int dones = 0;
        drive_start(1'b1);
        @(negedge clk);
        for (int c = 0; c < TOTAL + 2; c++) begin
            e = next_exp();
            a = sample_dut();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL seq cycle=%0d got=%h exp=%h", c, a, e);
            end
            if (a.done) dones++;
            if (c == 0) begin
                checks++;
                if ({a.rd_en, a.ra, a.rb, a.tw, a.wr_en} !== {1'b1, 4'd0, 4'd1, 3'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL cycle0_addr got=%h exp=%h", {a.rd_en, a.ra, a.rb, a.tw, a.wr_en},
                             {1'b1, 4'd0, 4'd1, 3'd0, 1'b0});
                end
            end
            if (c == 1) begin
                checks++;
                if ({a.ra, a.rb, a.tw, a.wr_en, a.wa, a.wb} !== {4'd2, 4'd3, 3'd0, 1'b1, 4'd0, 4'd1}) begin
                    errors++;
                    $display("FAIL cycle1_addr got=%h exp=%h", {a.ra, a.rb, a.tw, a.wr_en, a.wa, a.wb},
                             {4'd2, 4'd3, 3'd0, 1'b1, 4'd0, 4'd1});
                end
            end
            if (c == 23) begin
                checks++;
                if ({a.stage, a.ra, a.rb, a.tw} !== {4'd2, 4'd9, 4'd13, 3'd2}) begin
                    errors++;
                    $display("FAIL s2k5_addr got=%h exp=%h", {a.stage, a.ra, a.rb, a.tw},
                             {4'd2, 4'd9, 4'd13, 3'd2});
                end
            end
            if (c == 34) begin
                checks++;
                if ({a.stage, a.ra, a.rb, a.tw} !== {4'd3, 4'd7, 4'd15, 3'd7}) begin
                    errors++;
                    $display("FAIL s3k7_addr got=%h exp=%h", {a.stage, a.ra, a.rb, a.tw},
                             {4'd3, 4'd7, 4'd15, 3'd7});
                end
            end
            if (c inside {8, 17, 26, 35}) begin
                checks++;
                if ({a.rd_en, a.busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL drain_bubble cycle=%0d got rd_en,busy=%b exp=01", c, {a.rd_en, a.busy});
                end
            end
            if (c == TOTAL) begin
                checks++;
                if ({a.done, a.busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL done_cycle got done,busy=%b exp=10", {a.done, a.busy});
                end
            end
            drive_start(1'b0);
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL done_count got=%0d exp=1", dones);
        end
        $display("full transform: %0d done pulse(s)", dones);
    endtask

    task automatic test_start_ignored_back_to_back();
        obs_t e, a;
        int dones = 0;
        drive_start(1'b1);
        @(negedge clk);
        for (int c = 0; c < 2 * (TOTAL + 1) + 1; c++) begin
            e = next_exp();
            a = sample_dut();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL b2b cycle=%0d got=%h exp=%h", c, a, e);
            end
            if (a.done) dones++;
            if (c == TOTAL || c == 2 * TOTAL + 1) begin
                checks++;
                if ({a.done, a.busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_done cycle=%0d got done,busy=%b exp=10", c, {a.done, a.busy});
                end
            end
            if (c == TOTAL + 1) begin
                checks++;
                if ({a.stage, a.rd_en, a.ra, a.rb} !== {4'd0, 1'b1, 4'd0, 4'd1}) begin
                    errors++;
                    $display("FAIL restart got=%h exp=%h", {a.stage, a.rd_en, a.ra, a.rb},
                             {4'd0, 1'b1, 4'd0, 4'd1});
                end
            end
            drive_start(c == 5 || c == 20 || c == TOTAL);
            @(negedge clk);
        end
        drive_start(1'b0);
        checks++;
        if (dones != 2) begin
            errors++;
            $display("FAIL b2b_done_count got=%0d exp=2", dones);
        end
        $display("ignored-start/back-to-back: %0d done pulse(s)", dones);
    endtask

    task automatic test_reset_mid();
        obs_t e, a;
        int dones = 0;
        drive_start(1'b1);
        @(negedge clk);
        for (int c = 0; c <= 12; c++) begin
            e = next_exp();
            a = sample_dut();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pre_abort cycle=%0d got=%h exp=%h", c, a, e);
            end
            if (c < 12) begin
                drive_start(1'b0);
                @(negedge clk);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_en, wr_en, busy} !== 3'b000) begin
            errors++;
            $display("FAIL async_abort got rd_en,wr_en,busy=%b exp=000", {rd_en, wr_en, busy});
        end
        exp_q.delete();
        idle_stage = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            e = next_exp();
            a = sample_dut();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL post_abort_idle cycle=%0d got=%h exp=%h", c, a, e);
            end
            if (a.done) dones++;
            drive_start(1'b0);
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_done got=%0d pulses exp=0", dones);
        end
        drive_start(1'b1);
        @(negedge clk);
        for (int c = 0; c < TOTAL + 1; c++) begin
            e = next_exp();
            a = sample_dut();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL post_abort_seq cycle=%0d got=%h exp=%h", c, a, e);
            end
            if (c == 0) begin
                checks++;
                if ({a.rd_en, a.ra, a.rb, a.tw, a.stage} !== {1'b1, 4'd0, 4'd1, 3'd0, 4'd0}) begin
                    errors++;
                    $display("FAIL post_abort_cycle0 got=%h exp=%h", {a.rd_en, a.ra, a.rb, a.tw, a.stage},
                             {1'b1, 4'd0, 4'd1, 3'd0, 4'd0});
                end
            end
            drive_start(1'b0);
            @(negedge clk);
        end
        $display("mid-transform reset: transform restarted cleanly");
    endtask

    task automatic test_golden(input int pattern);
        obs_t e, a;
        real xr[N], xi[N];
        real er, ei, dr, di;
        bit got_done = 1'b0;
        for (int n = 0; n < N; n++) begin
            if (pattern == 0) begin
                xr[n] = (n == 0) ? 1.0 : 0.0;
                xi[n] = 0.0;
            end else begin
                xr[n] = real'(n + 1);
                xi[n] = real'((n * 3) % 5) - 2.0;
            end
        end
        for (int n = 0; n < N; n++) begin
            ram_re[bitrev(n)] = xr[n];
            ram_im[bitrev(n)] = xi[n];
        end
        drive_start(1'b1);
        @(negedge clk);
        for (int c = 0; c < 100 && !got_done; c++) begin
            e = next_exp();
            a = sample_dut();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL golden_seq pattern=%0d cycle=%0d got=%h exp=%h", pattern, c, a, e);
            end
            if (a.done) got_done = 1'b1;
            drive_start(1'b0);
            @(negedge clk);
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL golden_timeout pattern=%0d got no done exp done within 100 cycles", pattern);
        end
        for (int k = 0; k < N; k++) begin
            er = 0.0;
            ei = 0.0;
            for (int n = 0; n < N; n++) begin
                er += xr[n] * $cos(2.0 * PI * k * n / N) + xi[n] * $sin(2.0 * PI * k * n / N);
                ei += xi[n] * $cos(2.0 * PI * k * n / N) - xr[n] * $sin(2.0 * PI * k * n / N);
            end
            dr = ram_re[k] - er;
            di = ram_im[k] - ei;
            checks++;
            if ((dr < 0.0 ? -dr : dr) > 1e-6 || (di < 0.0 ? -di : di) > 1e-6) begin
                errors++;
                $display("FAIL golden_bin pattern=%0d k=%0d got=(%f,%f) exp=(%f,%f)",
                         pattern, k, ram_re[k], ram_im[k], er, ei);
            end
        end
        $display("golden transform pattern=%0d: %0d bins compared", pattern, N);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_stage0_sequence();
        test_start_ignored_back_to_back();
        test_reset_mid();
        test_golden(0);
        test_golden(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
